// File: rtl/io_port_ctrl_if.sv
// CPU-side register bus of the I/O port controller: strobes, select, write and read data.
interface io_port_ctrl_if;
  logic        pRead;
  logic        pWrite;
  logic [1:0]  addr;
  logic [11:0] pWriteData;
  logic [31:0] pReadData;

  modport master (
    output pRead,
    output pWrite,
    output addr,
    output pWriteData,
    input  pReadData
  );

  modport slave (
    input  pRead,
    input  pWrite,
    input  addr,
    input  pWriteData,
    output pReadData
  );
endinterface

// File: rtl/io_port_ctrl.sv
// Memory-mapped I/O port: debounced buttons, switch latch, LED register and ready flags.
// Optional sticky overrun flags in STATUS[3:2] when IO_OVERRUN_DETECT_EN is defined.
module io_port_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic           clk,
  input  logic           reset,
  io_port_ctrl_if.slave  bus,
  input  logic           btnL,
  input  logic           btnR,
  input  logic [15:0]    switch,
  output logic [11:0]    led
);

  // Button index 0 is btnL, index 1 is btnR.
  logic [1:0]            sync1_q, sync2_q;
  logic [1:0]            deb_q, deb_d, deb_prev_q;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]            pulse;

  logic [11:0] led_q, led_d;
  logic [15:0] sw_reg_q, sw_reg_d;
  logic        sw_ready_q, sw_ready_d;
  logic        led_ready_q, led_ready_d;
  logic        sw_rd, led_wr;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      deb_d[i] = deb_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          deb_d[i] = ~deb_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // deb_prev_q resets to the same value as deb_q, so reset release never looks like an edge.
  assign pulse = deb_q & ~deb_prev_q;

  // A simultaneous write to the same address suppresses the read side effect.
  assign sw_rd  = bus.pRead && !bus.pWrite && (bus.addr == 2'b01);
  assign led_wr = bus.pWrite && (bus.addr == 2'b10);

  always_comb begin
    led_d       = led_q;
    sw_reg_d    = sw_reg_q;
    sw_ready_d  = sw_ready_q;
    led_ready_d = led_ready_q;
    if (led_wr) begin
      led_d       = bus.pWriteData;
      led_ready_d = 1'b0;
    end
    if (sw_rd) sw_ready_d = 1'b0;
    // Set after clear so a same-cycle event is never lost.
    if (pulse[1]) begin
      sw_reg_d   = switch;
      sw_ready_d = 1'b1;
    end
    if (pulse[0]) led_ready_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      deb_prev_q  <= '0;
      cnt_q       <= '0;
      led_q       <= '0;
      sw_reg_q    <= '0;
      sw_ready_q  <= 1'b0;
      led_ready_q <= 1'b0;
    end else begin
      sync1_q     <= {btnR, btnL};
      sync2_q     <= sync1_q;
      deb_q       <= deb_d;
      deb_prev_q  <= deb_q;
      cnt_q       <= cnt_d;
      led_q       <= led_d;
      sw_reg_q    <= sw_reg_d;
      sw_ready_q  <= sw_ready_d;
      led_ready_q <= led_ready_d;
    end
  end

  assign led = led_q;

  logic [1:0] ovr;

`ifdef IO_OVERRUN_DETECT_EN
  logic [1:0] ovr_q, ovr_d;
  logic       st_wr;

  assign st_wr = bus.pWrite && (bus.addr == 2'b00);

  always_comb begin
    ovr_d = ovr_q;
    if (st_wr && bus.pWriteData[2]) ovr_d[0] = 1'b0;
    if (st_wr && bus.pWriteData[3]) ovr_d[1] = 1'b0;
    if (pulse[1] && sw_ready_q)     ovr_d[0] = 1'b1;
    if (pulse[0] && led_ready_q)    ovr_d[1] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ovr_q <= '0;
    else        ovr_q <= ovr_d;
  end

  assign ovr = ovr_q;
`else
  assign ovr = 2'b00;
`endif

  always_comb begin
    bus.pReadData = '0;
    if (bus.pRead) begin
      case (bus.addr)
        2'b00:   bus.pReadData = {28'b0, ovr, led_ready_q, sw_ready_q};
        2'b01:   bus.pReadData = {16'b0, sw_reg_q};
        2'b10:   bus.pReadData = {20'b0, led_q};
        default: bus.pReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_io_port_ctrl.sv
// Self-checking bench for io_port_ctrl with DEBOUNCE_CYCLES=4; inputs change on negedge.
module tb_io_port_ctrl;

  localparam int unsigned Deb = 4;

`ifdef IO_OVERRUN_DETECT_EN
  localparam logic [31:0] TwoPressStatus = 32'h5;
`else
  localparam logic [31:0] TwoPressStatus = 32'h1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        btnL = 1'b0;
  logic        btnR = 1'b0;
  logic [15:0] switch = 16'h0;
  logic [11:0] led;

  io_port_ctrl_if bus ();

  io_port_ctrl #(.DEBOUNCE_CYCLES(Deb)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .btnL   (btnL),
    .btnR   (btnR),
    .switch (switch),
    .led    (led)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  addr;
    logic [11:0] wdata;
    logic [31:0] exp_rd;
    logic [11:0] exp_led;
  } vec_t;

  sb_t  sb_q[$];
  vec_t tbl[13];
  int   nvec = 0;
  int   nerr = 0;

  task automatic sb_push(input string name, input logic [31:0] exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] act);
    sb_t e;
    nvec++;
    if (sb_q.size() == 0) begin
      nerr++;
      $display("FAIL scoreboard_empty: got %h with nothing expected", act);
    end else begin
      e = sb_q.pop_front();
      if (act !== e.exp) begin
        nerr++;
        $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
      end
    end
  endtask

  // Entered and left on a negedge; sample 4 ns later, still inside the low phase.
  task automatic bus_rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    bus.pRead = 1'b1;
    bus.addr  = a;
    sb_push(name, exp);
    #4;
    sb_check(bus.pReadData);
    @(negedge clk);
    bus.pRead = 1'b0;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [11:0] d);
    bus.pWrite     = 1'b1;
    bus.addr       = a;
    bus.pWriteData = d;
    @(negedge clk);
    bus.pWrite = 1'b0;
  endtask

  // One clock with the current inputs, then compare the combinational read data.
  task automatic tick_chk(input logic [31:0] exp, input string name);
    sb_push(name, exp);
    @(negedge clk);
    sb_check(bus.pReadData);
  endtask

  task automatic press(input bit right, input logic [15:0] sw);
    switch = sw;
    if (right) btnR = 1'b1;
    else       btnL = 1'b1;
    repeat (10) @(negedge clk);
    btnR = 1'b0;
    btnL = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    logic [13:0] pat;

    tbl[0]  = '{1'b1, 1'b0, 2'b00, 12'h000, 32'h0,      12'h000};
    tbl[1]  = '{1'b1, 1'b0, 2'b01, 12'h000, 32'h0,      12'h000};
    tbl[2]  = '{1'b1, 1'b0, 2'b10, 12'h000, 32'h0,      12'h000};
    tbl[3]  = '{1'b1, 1'b0, 2'b11, 12'h000, 32'h0,      12'h000};
    tbl[4]  = '{1'b0, 1'b0, 2'b10, 12'h000, 32'h0,      12'h000};
    tbl[5]  = '{1'b0, 1'b1, 2'b10, 12'hA5C, 32'h0,      12'h000};
    tbl[6]  = '{1'b1, 1'b0, 2'b10, 12'h000, 32'h00000A5C, 12'hA5C};
    tbl[7]  = '{1'b0, 1'b0, 2'b10, 12'h000, 32'h0,      12'hA5C};
    tbl[8]  = '{1'b1, 1'b1, 2'b11, 12'hFFF, 32'h0,      12'hA5C};
    tbl[9]  = '{1'b1, 1'b0, 2'b10, 12'h000, 32'h00000A5C, 12'hA5C};
    tbl[10] = '{1'b1, 1'b1, 2'b00, 12'hFFF, 32'h0,      12'hA5C};
    tbl[11] = '{1'b1, 1'b1, 2'b10, 12'h000, 32'h00000A5C, 12'hA5C};
    tbl[12] = '{1'b1, 1'b0, 2'b10, 12'h000, 32'h0,      12'h000};

    bus.pRead      = 1'b0;
    bus.pWrite     = 1'b0;
    bus.addr       = 2'b00;
    bus.pWriteData = 12'h000;

    // Reset low for 3 cycles.
    repeat (3) @(negedge clk);
    sb_push("led_in_reset", 32'h0);
    sb_check({20'b0, led});
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Register map and LED write behaviour.
    for (int i = 0; i < 13; i++) begin
      bus.pRead      = tbl[i].rd;
      bus.pWrite     = tbl[i].wr;
      bus.addr       = tbl[i].addr;
      bus.pWriteData = tbl[i].wdata;
      sb_push($sformatf("vec%0d_rdata", i), tbl[i].exp_rd);
      sb_push($sformatf("vec%0d_led", i), {20'b0, tbl[i].exp_led});
      #4;
      sb_check(bus.pReadData);
      sb_check({20'b0, led});
      @(negedge clk);
    end
    bus.pRead  = 1'b0;
    bus.pWrite = 1'b0;

    // btnR latency: STATUS goes to 1 exactly 7 cycles after the raw edge.
    switch    = 16'hBEEF;
    btnR      = 1'b1;
    bus.pRead = 1'b1;
    bus.addr  = 2'b00;
    for (int k = 1; k <= 7; k++) begin
      tick_chk((k == 7) ? 32'h1 : 32'h0, $sformatf("latency_c%0d", k));
    end
    bus.pRead = 1'b0;
    repeat (3) @(negedge clk);
    btnR = 1'b0;
    bus_rd(2'b01, 32'h0000BEEF, "switch_beef");
    bus_rd(2'b00, 32'h0, "status_after_sw_read");
    repeat (10) @(negedge clk);

    // Glitchy press: high 3, low 1, high 3 never completes a debounce.
    switch    = 16'h0F0F;
    pat       = 14'b00000001110111;
    bus.pRead = 1'b1;
    bus.addr  = 2'b00;
    for (int k = 0; k < 14; k++) begin
      btnR = pat[k];
      tick_chk(32'h0, $sformatf("glitch_c%0d", k));
    end
    // Clean 6-cycle press gives exactly one event.
    btnR = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      if (k == 7) btnR = 1'b0;
      tick_chk((k == 7) ? 32'h1 : 32'h0, $sformatf("hold6_c%0d", k));
    end
    bus.pRead = 1'b0;
    bus_rd(2'b01, 32'h00000F0F, "switch_0f0f");
    repeat (10) @(negedge clk);
    bus_rd(2'b00, 32'h0, "single_event");

    // btnL sets led_ready; LED write clears it.
    press(1'b0, 16'h0F0F);
    bus_rd(2'b00, 32'h2, "status_led_ready");
    bus_wr(2'b10, 12'hA5C);
    sb_push("led_after_write", 32'h00000A5C);
    sb_check({20'b0, led});
    bus_rd(2'b00, 32'h0, "status_after_led_write");
    bus_rd(2'b10, 32'h00000A5C, "led_readback");

    // btnR pulse coincides with a SWITCH read: the set wins.
    switch = 16'h5678;
    btnR   = 1'b1;
    repeat (6) @(negedge clk);
    bus_rd(2'b01, 32'h00000F0F, "switch_during_pulse");
    btnR = 1'b0;
    bus_rd(2'b00, 32'h1, "status_set_wins");
    bus_rd(2'b01, 32'h00005678, "switch_new_value");
    bus_rd(2'b00, 32'h0, "status_cleared");
    repeat (10) @(negedge clk);

    // Two btnR presses with no read in between.
    press(1'b1, 16'h1111);
    press(1'b1, 16'h2222);
    bus_rd(2'b00, TwoPressStatus, "status_two_presses");
    bus_wr(2'b00, 12'h004);
    bus_rd(2'b00, 32'h1, "status_after_w1c");
    bus_rd(2'b01, 32'h00002222, "switch_overwritten");
    bus_rd(2'b00, 32'h0, "status_final_clear");

    // Asynchronous reset in the middle of a btnL debounce.
    bus_wr(2'b10, 12'h3C3);
    btnL = 1'b1;
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    sb_push("led_async_reset", 32'h0);
    sb_check({20'b0, led});
    btnL = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    bus_rd(2'b00, 32'h0, "status_after_abort");

    if (sb_q.size() != 0) begin
      nerr++;
      $display("FAIL scoreboard_leftover: got %0d entries, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/io_port_ctrl.md
Name: io_port_ctrl

Overview:
- Memory-mapped I/O port controller that sits directly behind the data-memory address decoder of the multi-cycle MIPS core.
- Debounces the two push-buttons (btnL, btnR) and latches the 16 slide switches on a btnR press.
- Holds the 12-bit LED register written by software, and exposes ready flags so polling code can handshake with the user.
- The 12-bit LED value feeds the downstream 7-segment display multiplexer.

Parameters:
- DEBOUNCE_CYCLES, 100000: consecutive stable cycles required before a button change is accepted (1 ms at 100 MHz). Minimum 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): debounce counter width (derived).

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- pRead  in  1  I/O read strobe from the decoder (address in I/O space)
- pWrite  in  1  I/O write strobe from the decoder
- addr  in  2  register select (CPU byte address bits [3:2])
- pWriteData  in  12  write data (CPU writeData[11:0])
- pReadData  out  32  read data, combinational
- btnL  in  1  raw push-button, "LED ready" request
- btnR  in  1  raw push-button, "switches ready" request
- switch  in  16  raw slide switches
- led  out  12  LED register

Behaviour:
- Register map (addr):
  - 00 STATUS (R): {30'b0, led_ready, sw_ready}.
  - 01 SWITCH (R): {16'b0, sw_reg}.
  - 10 LED (R/W): read returns {20'b0, led}.
  - 11 reserved: reads 0, writes ignored.
- Reset (reset==0, asynchronous): led, sw_reg, sw_ready, led_ready, synchronizer flops, debounced levels and counters all go to 0.
  - Asserting reset mid-debounce aborts the count.
  - No button event is generated on reset release.
- Input sync: btnL and btnR each pass through a 2-FF synchronizer. switch is sampled only at latch time; no synchronizer is needed because it is quasi-static.
- Debounce, per button:
  - If the synced level equals the debounced level, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the level still differs, the debounced level toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES resets progress.
- Event: a rising edge of a debounced level produces a 1-cycle pulse.
  - Latency from raw edge to pulse: 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
- btnR pulse: sw_reg <= switch and sw_ready <= 1 in the same cycle.
- btnL pulse: led_ready <= 1.
- SWITCH read: any cycle with pRead && addr==01 clears sw_ready at the next edge. sw_reg is unchanged, so a multi-cycle read stays stable.
- LED write: pWrite && addr==10 gives led <= pWriteData and led_ready <= 0 at the next edge.
  - Writes are accepted regardless of led_ready.
  - pWrite has priority over any read side effect on the same address.
- Simultaneous set and clear of one flag in the same cycle: set wins, so events are never lost. For btnR, sw_reg takes the new switch value.
- pReadData is valid whenever pRead is high. It is driven to 0 when pRead==0.
- Back-to-back btnR presses without an intervening read: sw_reg is overwritten with the latest value and sw_ready stays 1.

Optional Feature:
- Macro: IO_OVERRUN_DETECT_EN.
- Defined:
  - STATUS bit2 = sw_overrun: set by a btnR pulse while sw_ready==1.
  - STATUS bit3 = led_overrun: set by a btnL pulse while led_ready==1.
  - Writing STATUS (addr 00) with pWriteData bit2/bit3 = 1 clears the corresponding bit (write-1-to-clear).
  - If a set and a W1C land in the same cycle, set wins.
  - Both bits reset to 0.
- Not defined: STATUS bits [31:2] read 0; writes to addr 00 are ignored; no overrun state is synthesized.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset low for 3 cycles, then release → led==0; STATUS, SWITCH and LED reads all ==0; no pulse after release.
- switch=16'hBEEF; btnR held high 10 cycles → STATUS==1 exactly 7 cycles after the raw edge; SWITCH read ==32'h0000BEEF; STATUS==0 the cycle after the read.
- btnR high 3 cycles, low 1, high 3 → no event and STATUS stays 0. Then hold btnR high 6 cycles → a single event.
- btnL pressed → STATUS==2. Write addr 10 with 12'hA5C → led==12'hA5C and STATUS==0 next cycle. LED read ==32'h00000A5C.
- Align the btnR pulse with pRead&&addr==01 in the same cycle → sw_ready==1 afterwards; sw_reg holds the new switch value.
- With IO_OVERRUN_DETECT_EN defined: two btnR presses with no read → STATUS==5. Write addr 00 data 12'h004 → STATUS==1. Without the macro, the same stimulus → STATUS==1.
